// File: rtl/pll_mon_pkg.sv
// Shared state type and constants for the PLL lock monitor.
package pll_mon_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_EVAL    = 2'd3
  } pll_mon_state_t;

  localparam int PLL_MON_MIN_SYNC = 2;

  // Synchronizer depth never drops below the metastability-safe minimum.
  function automatic int sync_depth(input int requested);
    return (requested < PLL_MON_MIN_SYNC) ? PLL_MON_MIN_SYNC : requested;
  endfunction
endpackage

// File: rtl/pll_lock_monitor_if.sv
// Control/status bundle of the PLL lock monitor; master drives requests, slave is the monitor.
interface pll_lock_monitor_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             continuous;
  logic [WIN_W-1:0] settle_cycles;
  logic [WIN_W-1:0] win_cycles;
  logic [CNT_W-1:0] min_edges;
  logic [CNT_W-1:0] max_edges;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] edge_count;
  logic             locked;
  logic             lost;

  modport master (
    output start, abort, continuous, settle_cycles, win_cycles, min_edges, max_edges,
    input  busy, done, pass, edge_count, locked, lost
  );

  modport slave (
    input  start, abort, continuous, settle_cycles, win_cycles, min_edges, max_edges,
    output busy, done, pass, edge_count, locked, lost
  );
endinterface

// File: rtl/clk_edge_sync.sv
// Synchronizes an asynchronous clock into the CLK domain and flags its rising edges.
module clk_edge_sync
  import pll_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  localparam int STAGES = sync_depth(SYNC_STAGES);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~dly_q;
endmodule

// File: rtl/pll_lock_monitor.sv
// Counts synchronized input_clock edges per window, checks a band and tracks lock over consecutive passes.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int WIN_W       = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_PASSES = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              input_clock,
  pll_lock_monitor_if.slave bus
);
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_PASSES);

  pll_mon_state_t   state;
  logic [WIN_W-1:0] cnt;
  logic [WIN_W-1:0] win_len;
  logic [WIN_W-1:0] win_req;
  logic [CNT_W-1:0] edges;
  logic [CNT_W-1:0] edges_next;
  logic [CNT_W-1:0] min_q;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] count_q;
  logic [3:0]       pass_run;
  logic             cont_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             locked_q;
  logic             lost_q;
  logic             rise;
  logic             win_pass;

  clk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .din  (input_clock),
    .rise (rise)
  );

  // The result is judged on the count including the edge seen in the final window cycle.
  always_comb begin
    win_req    = (bus.win_cycles == '0) ? WIN_W'(1) : bus.win_cycles;
    edges_next = edges;
    if (rise && (edges != '1)) edges_next = edges + CNT_W'(1);
    win_pass   = (min_q <= max_q) && (edges_next >= min_q) && (edges_next <= max_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      win_len  <= '0;
      edges    <= '0;
      min_q    <= '0;
      max_q    <= '0;
      count_q  <= '0;
      pass_run <= '0;
      cont_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      lost_q <= 1'b0;
      if (bus.abort && (state != ST_IDLE)) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        busy_q   <= 1'b0;
        locked_q <= 1'b0;
        pass_run <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (bus.start && !bus.abort) begin
              cont_q   <= bus.continuous;
              win_len  <= win_req;
              min_q    <= bus.min_edges;
              max_q    <= bus.max_edges;
              pass_run <= '0;
              edges    <= '0;
              busy_q   <= 1'b1;
              if (bus.settle_cycles != '0) begin
                state <= ST_SETTLE;
                cnt   <= bus.settle_cycles;
              end else begin
                state <= ST_MEASURE;
                cnt   <= win_req;
              end
            end
          end
          ST_SETTLE: begin
            if (cnt == WIN_W'(1)) begin
              state <= ST_MEASURE;
              cnt   <= win_len;
              edges <= '0;
            end else begin
              cnt <= cnt - WIN_W'(1);
            end
          end
          ST_MEASURE: begin
            edges <= edges_next;
            if (cnt == WIN_W'(1)) begin
              // Results and the lost/unlock decision are registered into the EVAL cycle itself.
              state   <= ST_EVAL;
              count_q <= edges_next;
              pass_q  <= win_pass;
              done_q  <= 1'b1;
              if (win_pass) begin
                pass_run <= (pass_run == LOCK_TARGET) ? pass_run : pass_run + 4'd1;
              end else begin
                pass_run <= '0;
                if (locked_q) begin
                  locked_q <= 1'b0;
                  lost_q   <= 1'b1;
                end
              end
            end else begin
              cnt <= cnt - WIN_W'(1);
            end
          end
          ST_EVAL: begin
            if (pass_run == LOCK_TARGET) locked_q <= 1'b1;
            if (cont_q) begin
              state <= ST_MEASURE;
              cnt   <= win_len;
              edges <= '0;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.edge_count = count_q;
  assign bus.locked     = locked_q;
  assign bus.lost       = lost_q;
endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: window timing, band check, lock/lost, abort, reset, saturation, random windows.
module tb_pll_lock_monitor;
  localparam int N_SYNC = 2;
  localparam int LP     = 4;

  logic CLK         = 1'b0;
  logic RST_N       = 1'b0;
  logic input_clock = 1'b0;
  logic ick_level   = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_done = 0;
  int   n_lost = 0;
  int   ick_mode = 0;
  int   ick_half = 5;
  int   ick_ph   = 0;
  bit   ick_hist [0:65535];
  bit   res_q[$];
  int   g_count;
  bit   g_pass;

  pll_lock_monitor_if #(.WIN_W(16), .CNT_W(16)) bus ();
  pll_lock_monitor_if #(.WIN_W(16), .CNT_W(4))  bus4 ();

  pll_lock_monitor #(.WIN_W(16), .CNT_W(16), .SYNC_STAGES(N_SYNC), .LOCK_PASSES(LP)) dut (
    .CLK(CLK), .RST_N(RST_N), .input_clock(input_clock), .bus(bus)
  );
  pll_lock_monitor #(.WIN_W(16), .CNT_W(4), .SYNC_STAGES(N_SYNC), .LOCK_PASSES(LP)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .input_clock(input_clock), .bus(bus4)
  );

  always #5 CLK = ~CLK;

  // cyc == k after the k-th rising edge; ick_hist[k] is what the DUT sampled at that edge.
  always @(posedge CLK) begin
    cyc = cyc + 1;
    ick_hist[cyc] = input_clock;
  end

  always @(posedge CLK) begin
    #1;
    if (ick_mode == 1) begin
      ick_ph = ick_ph + 1;
      if (ick_ph >= ick_half) begin
        ick_ph = 0;
        input_clock = ~input_clock;
      end
    end else if (ick_mode == 2) begin
      input_clock = 1'($urandom_range(0, 1));
    end else begin
      input_clock = ick_level;
    end
  end

  always @(negedge CLK) begin
    if (bus.done === 1'b1) n_done = n_done + 1;
    if (bus.lost === 1'b1) n_lost = n_lost + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Rising edges of input_clock counted in a window whose first counting cycle is mstart,
  // shifted by the synchronizer latency.
  function automatic int model_count(input int mstart, input int w, input int sat);
    int n = 0;
    for (int p = mstart + 1 - N_SYNC; p <= mstart + w - N_SYNC; p++)
      if (ick_hist[p] && !ick_hist[p-1]) n++;
    return (n > sat) ? sat : n;
  endfunction

  function automatic int trailing_passes();
    int n = 0;
    for (int i = res_q.size() - 1; i >= 0; i--) begin
      if (!res_q[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic do_start(input bit cont, input int s, input int w, input int mn, input int mx,
                          output int t0);
    bus.continuous    = cont;
    bus.settle_cycles = 16'(s);
    bus.win_cycles    = 16'(w);
    bus.min_edges     = 16'(mn);
    bus.max_edges     = 16'(mx);
    bus.start         = 1'b1;
    t0 = cyc;
    tick();
    bus.start         = 1'b0;
    bus.continuous    = 1'($urandom_range(0, 1));
    bus.settle_cycles = 16'($urandom);
    bus.win_cycles    = 16'($urandom);
    bus.min_edges     = 16'($urandom);
    bus.max_edges     = 16'($urandom);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL reset_pass got=%b want=0", bus.pass); end
    checks++; if (bus.edge_count !== 16'd0) begin errors++; $display("FAIL reset_edge_count got=%0d want=0", bus.edge_count); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b want=0", bus.locked); end
    checks++; if (bus.lost !== 1'b0) begin errors++; $display("FAIL reset_lost got=%b want=0", bus.lost); end
    checks++; if (bus4.edge_count !== 4'd0) begin errors++; $display("FAIL reset_edge_count4 got=%0d want=0", bus4.edge_count); end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_one_shot();
    int t0, at, got;
    ick_mode = 1; ick_half = 5;
    repeat (25) tick();
    do_start(1'b0, 8, 100, 9, 11, t0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL oneshot_busy got=%b want=1", bus.busy); end
    at = -1;
    for (int i = 0; i < 130 && at < 0; i++) begin tick(); if (bus.done === 1'b1) at = cyc; end
    checks++; if (at != t0 + 109) begin errors++; $display("FAIL oneshot_done_time got=%0d want=%0d", at, t0 + 109); end
    got = model_count(t0 + 9, 100, 65535);
    checks++; if (bus.edge_count !== 16'(got)) begin errors++; $display("FAIL oneshot_edge_count got=%0d want=%0d", bus.edge_count, got); end
    checks++; if (bus.pass !== ((got >= 9) && (got <= 11))) begin errors++; $display("FAIL oneshot_pass got=%b want=%b", bus.pass, (got >= 9) && (got <= 11)); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL oneshot_busy_after got=%b want=0", bus.busy); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL oneshot_locked got=%b want=0", bus.locked); end
  endtask

  // Windows 0-4 clock running, 5-6 clock stopped, 7-12 clock running again.
  task automatic test_continuous_lock();
    int t0, at, got, run_before, mstart, lost0;
    bit ep;
    lost0 = n_lost;
    ick_mode = 1; ick_half = 5;
    repeat (20) tick();
    res_q.delete();
    do_start(1'b1, 8, 100, 9, 11, t0);
    mstart = t0 + 9;
    for (int k = 0; k < 13; k++) begin
      if (k == 5) begin ick_level = 1'b0; ick_mode = 0; end
      if (k == 7) ick_mode = 1;
      at = -1;
      for (int i = 0; i < 115 && at < 0; i++) begin tick(); if (bus.done === 1'b1) at = cyc; end
      checks++; if (at != mstart + 100) begin errors++; $display("FAIL cont_done_time win=%0d got=%0d want=%0d", k, at, mstart + 100); end
      got = model_count(mstart, 100, 65535);
      ep = (got >= 9) && (got <= 11);
      run_before = trailing_passes();
      checks++; if (bus.edge_count !== 16'(got)) begin errors++; $display("FAIL cont_edge_count win=%0d got=%0d want=%0d", k, bus.edge_count, got); end
      checks++; if (bus.pass !== ep) begin errors++; $display("FAIL cont_pass win=%0d got=%b want=%b", k, bus.pass, ep); end
      checks++; if (bus.lost !== (!ep && run_before >= LP)) begin errors++; $display("FAIL cont_lost win=%0d got=%b want=%b", k, bus.lost, !ep && run_before >= LP); end
      checks++; if (bus.locked !== (ep && run_before >= LP)) begin errors++; $display("FAIL cont_locked_at_done win=%0d got=%b want=%b", k, bus.locked, ep && run_before >= LP); end
      res_q.push_back(ep);
      g_count = got;
      g_pass  = ep;
      tick();
      checks++; if (bus.locked !== (trailing_passes() >= LP)) begin errors++; $display("FAIL cont_locked_next win=%0d got=%b want=%b", k, bus.locked, trailing_passes() >= LP); end
      mstart = mstart + 101;
    end
    checks++; if (n_lost - lost0 != 1) begin errors++; $display("FAIL cont_lost_pulses got=%0d want=1", n_lost - lost0); end
  endtask

  task automatic test_abort();
    int d0, l0;
    repeat (50) tick();
    checks++; if (bus.locked !== (trailing_passes() >= LP)) begin errors++; $display("FAIL abort_pre_locked got=%b want=%b", bus.locked, trailing_passes() >= LP); end
    d0 = n_done; l0 = n_lost;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL abort_locked got=%b want=0", bus.locked); end
    checks++; if (bus.edge_count !== 16'(g_count)) begin errors++; $display("FAIL abort_edge_count_hold got=%0d want=%0d", bus.edge_count, g_count); end
    checks++; if (bus.pass !== g_pass) begin errors++; $display("FAIL abort_pass_hold got=%b want=%b", bus.pass, g_pass); end
    repeat (120) tick();
    checks++; if (n_done != d0) begin errors++; $display("FAIL abort_no_done got=%0d want=%0d", n_done, d0); end
    checks++; if (n_lost != l0) begin errors++; $display("FAIL abort_no_lost got=%0d want=%0d", n_lost, l0); end
  endtask

  task automatic test_start_while_busy();
    int t0, at, got, d0;
    d0 = n_done;
    do_start(1'b0, 8, 100, 9, 11, t0);
    repeat (10) tick();
    bus.continuous = 1'b1; bus.settle_cycles = '0; bus.win_cycles = '0;
    bus.min_edges = '0; bus.max_edges = '0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    at = -1;
    for (int i = 0; i < 130 && at < 0; i++) begin tick(); if (bus.done === 1'b1) at = cyc; end
    checks++; if (at != t0 + 109) begin errors++; $display("FAIL busy_start_done_time got=%0d want=%0d", at, t0 + 109); end
    got = model_count(t0 + 9, 100, 65535);
    checks++; if (bus.edge_count !== 16'(got)) begin errors++; $display("FAIL busy_start_edge_count got=%0d want=%0d", bus.edge_count, got); end
    repeat (150) tick();
    checks++; if (n_done - d0 != 1) begin errors++; $display("FAIL busy_start_done_pulses got=%0d want=1", n_done - d0); end
  endtask

  task automatic test_reset_mid();
    int t0, d0;
    do_start(1'b0, 40, 100, 9, 11, t0);
    repeat (10) tick();
    d0 = n_done;
    RST_N = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL rstmid_pass got=%b want=0", bus.pass); end
    checks++; if (bus.edge_count !== 16'd0) begin errors++; $display("FAIL rstmid_edge_count got=%0d want=0", bus.edge_count); end
    checks++; if (bus.locked !== 1'b0 || bus.lost !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_status got=%b%b%b want=000", bus.locked, bus.lost, bus.done); end
    RST_N = 1'b1;
    repeat (160) tick();
    checks++; if (n_done != d0) begin errors++; $display("FAIL rstmid_no_done got=%0d want=%0d", n_done, d0); end
  endtask

  task automatic test_zero_window();
    int t0, at;
    ick_level = 1'b1; ick_mode = 0;
    repeat (10) tick();
    do_start(1'b0, 0, 0, 5, 3, t0);
    at = -1;
    for (int i = 0; i < 10 && at < 0; i++) begin tick(); if (bus.done === 1'b1) at = cyc; end
    checks++; if (at != t0 + 2) begin errors++; $display("FAIL zero_done_time got=%0d want=%0d", at, t0 + 2); end
    checks++; if (bus.edge_count !== 16'd0) begin errors++; $display("FAIL zero_edge_count got=%0d want=0", bus.edge_count); end
    checks++; if (bus.pass !== 1'b0) begin errors++; $display("FAIL zero_inverted_band_pass got=%b want=0", bus.pass); end
    repeat (2) tick();
    do_start(1'b0, 0, 0, 0, 0, t0);
    at = -1;
    for (int i = 0; i < 10 && at < 0; i++) begin tick(); if (bus.done === 1'b1) at = cyc; end
    checks++; if (at != t0 + 2) begin errors++; $display("FAIL zero2_done_time got=%0d want=%0d", at, t0 + 2); end
    checks++; if (bus.pass !== 1'b1) begin errors++; $display("FAIL zero2_band00_pass got=%b want=1", bus.pass); end
    repeat (2) tick();
  endtask

  task automatic test_saturation();
    int t0, at, got;
    ick_mode = 1; ick_half = 1;
    repeat (10) tick();
    bus4.continuous = 1'b0; bus4.settle_cycles = '0; bus4.win_cycles = 16'd100;
    bus4.min_edges = 4'd14; bus4.max_edges = 4'd15; bus4.start = 1'b1;
    t0 = cyc;
    tick();
    bus4.start = 1'b0;
    at = -1;
    for (int i = 0; i < 120 && at < 0; i++) begin tick(); if (bus4.done === 1'b1) at = cyc; end
    checks++; if (at != t0 + 101) begin errors++; $display("FAIL sat_done_time got=%0d want=%0d", at, t0 + 101); end
    checks++; if (bus4.edge_count !== 4'd15) begin errors++; $display("FAIL sat_edge_count got=%0d want=15", bus4.edge_count); end
    checks++; if (bus4.pass !== 1'b1) begin errors++; $display("FAIL sat_pass got=%b want=1", bus4.pass); end
    repeat (2) tick();
    bus4.settle_cycles = 16'd3; bus4.win_cycles = 16'd20;
    bus4.min_edges = 4'd0; bus4.max_edges = 4'd15; bus4.start = 1'b1;
    t0 = cyc;
    tick();
    bus4.start = 1'b0;
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin tick(); if (bus4.done === 1'b1) at = cyc; end
    got = model_count(t0 + 4, 20, 15);
    checks++; if (at != t0 + 24) begin errors++; $display("FAIL sat20_done_time got=%0d want=%0d", at, t0 + 24); end
    checks++; if (bus4.edge_count !== 4'(got)) begin errors++; $display("FAIL sat20_edge_count got=%0d want=%0d", bus4.edge_count, got); end
    repeat (2) tick();
  endtask

  task automatic test_random();
    int t0, at, got, s, w, weff, mn, mx;
    ick_mode = 2;
    repeat (5) tick();
    for (int it = 0; it < 12; it++) begin
      s  = $urandom_range(0, 20);
      w  = $urandom_range(0, 60);
      mn = $urandom_range(0, 30);
      mx = $urandom_range(0, 30);
      weff = (w == 0) ? 1 : w;
      do_start(1'b0, s, w, mn, mx, t0);
      at = -1;
      for (int i = 0; i < s + weff + 10 && at < 0; i++) begin tick(); if (bus.done === 1'b1) at = cyc; end
      checks++; if (at != t0 + 1 + s + weff) begin errors++; $display("FAIL rand_done_time it=%0d got=%0d want=%0d", it, at, t0 + 1 + s + weff); end
      got = model_count(t0 + 1 + s, weff, 65535);
      checks++; if (bus.edge_count !== 16'(got)) begin errors++; $display("FAIL rand_edge_count it=%0d got=%0d want=%0d", it, bus.edge_count, got); end
      checks++; if (bus.pass !== ((mn <= got) && (got <= mx))) begin errors++; $display("FAIL rand_pass it=%0d got=%b want=%b", it, bus.pass, (mn <= got) && (got <= mx)); end
      repeat (2) tick();
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.continuous = 1'b0;
    bus.settle_cycles = '0; bus.win_cycles = '0; bus.min_edges = '0; bus.max_edges = '0;
    bus4.start = 1'b0; bus4.abort = 1'b0; bus4.continuous = 1'b0;
    bus4.settle_cycles = '0; bus4.win_cycles = '0; bus4.min_edges = '0; bus4.max_edges = '0;
    test_reset();
    test_one_shot();
    test_continuous_lock();
    test_abort();
    test_start_while_busy();
    test_reset_mid();
    test_zero_window();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
